// File: rtl/pwm_ramp_ctrl.sv
// Ramped duty-word controller for a 256-clock PWM divider: steps duty_out by 1 every STEP_DIV periods.
// Optional mid-ramp retargeting is enabled by defining PWM_RAMP_RETARGET_EN.
module pwm_ramp_ctrl #(
  parameter int STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tgt_duty,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic       hold,
  output logic [7:0] duty_out,
  output logic       period_start,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RAMP, PAUSE} state_t;

  localparam logic [7:0] SDIV_LAST = 8'(STEP_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] phase;
  logic [7:0] sdiv, sdiv_nxt;
  logic [7:0] target, target_nxt;
  logic [7:0] duty, duty_nxt;
  logic       done_q, done_nxt;
  logic       wrap, hs, retgt, step_edge;
  logic [7:0] stepped;

  // Unsigned one-LSB move toward the target; holds when already there, so it can never wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)
      return cur + 8'd1;
    else if (cur > tgt)
      return cur - 8'd1;
    else
      return cur;
  endfunction

`ifdef PWM_RAMP_RETARGET_EN
  assign tgt_ready = 1'b1;
  assign retgt     = hs;
`else
  assign tgt_ready = (state == IDLE);
  assign retgt     = 1'b0;
`endif

  assign hs           = tgt_valid & tgt_ready;
  assign wrap         = (phase == 8'hFF);
  assign step_edge    = wrap && (sdiv == SDIV_LAST);
  assign stepped      = step_toward(duty, target);
  assign period_start = (phase == 8'd0);
  assign busy         = (state != IDLE);
  assign duty_out     = duty;
  assign done         = done_q;

  always_comb begin
    state_nxt  = state;
    sdiv_nxt   = sdiv;
    target_nxt = target;
    duty_nxt   = duty;
    done_nxt   = 1'b0;
    if (hs)
      target_nxt = tgt_duty;
    case (state)
      IDLE: begin
        if (hs) begin
          if (tgt_duty != duty) begin
            state_nxt = RAMP;
            sdiv_nxt  = '0;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RAMP: begin
        if (retgt) begin
          sdiv_nxt = '0;
          if (tgt_duty == duty) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (hold) begin
            state_nxt = PAUSE;
          end
        end else begin
          // Duty only moves on the 255->0 wrap so the divider sees whole periods.
          if (step_edge) begin
            sdiv_nxt = '0;
            duty_nxt = stepped;
          end else if (wrap) begin
            sdiv_nxt = sdiv + 8'd1;
          end
          if (step_edge && (stepped == target)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (hold) begin
            state_nxt = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (retgt) begin
          sdiv_nxt = '0;
          if (tgt_duty == duty) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else if (!hold) begin
          state_nxt = RAMP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      phase  <= '0;
      sdiv   <= '0;
      target <= '0;
      duty   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      phase  <= phase + 8'd1;
      sdiv   <= sdiv_nxt;
      target <= target_nxt;
      duty   <= duty_nxt;
      done_q <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: dut_a uses STEP_DIV=4, dut_b uses STEP_DIV=1 for faster range checks.
module tb_pwm_ramp_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PWM_RAMP_RETARGET_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic       rst_n_a, tgt_valid_a, hold_a, tgt_ready_a, ps_a, busy_a, done_a;
  logic [7:0] tgt_duty_a, duty_a;
  logic       rst_n_b, tgt_valid_b, hold_b, tgt_ready_b, ps_b, busy_b, done_b;
  logic [7:0] tgt_duty_b, duty_b;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_ramp_ctrl #(.STEP_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .tgt_duty(tgt_duty_a), .tgt_valid(tgt_valid_a),
    .tgt_ready(tgt_ready_a), .hold(hold_a), .duty_out(duty_a),
    .period_start(ps_a), .busy(busy_a), .done(done_a)
  );

  pwm_ramp_ctrl #(.STEP_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .tgt_duty(tgt_duty_b), .tgt_valid(tgt_valid_b),
    .tgt_ready(tgt_ready_b), .hold(hold_b), .duty_out(duty_b),
    .period_start(ps_b), .busy(busy_b), .done(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_n_a = 1'b0; tgt_valid_a = 1'b0; hold_a = 1'b0;
    tick();
    rst_n_a = 1'b1;
  endtask

  task automatic reset_b();
    rst_n_b = 1'b0; tgt_valid_b = 1'b0; hold_b = 1'b0;
    tick();
    rst_n_b = 1'b1;
  endtask

  // Handshake a target in the current cycle, then run until done (bounded); caller checks the outcome.
  task automatic ramp_a_to(input logic [7:0] t);
    tgt_duty_a = t; tgt_valid_a = 1'b1;
    tick();
    tgt_valid_a = 1'b0;
    for (int k = 0; k < 12000 && done_a !== 1'b1; k++) tick();
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    tick();
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    n_checks++; if (duty_a !== 8'd0) $display("FAIL reset_duty: got %0d expected 0", duty_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_a); else n_pass++;
    n_checks++; if (ps_a !== 1'b1) $display("FAIL reset_period_start: got %b expected 1", ps_a); else n_pass++;
    n_checks++; if (tgt_ready_a !== 1'b1) $display("FAIL reset_ready: got %b expected 1", tgt_ready_a); else n_pass++;
    n_checks++; if (duty_b !== 8'd0 || ps_b !== 1'b1) $display("FAIL reset_b: got duty %0d ps %b expected 0 1", duty_b, ps_b); else n_pass++;
    tick();
    n_checks++; if (ps_a !== 1'b0) $display("FAIL phase_cycle1: got period_start %b expected 0", ps_a); else n_pass++;
    for (int k = 1; k < 256; k++) tick();
    n_checks++; if (ps_a !== 1'b1) $display("FAIL phase_wrap: got period_start %b expected 1 at cycle 256", ps_a); else n_pass++;
  endtask

  task automatic test_ramp_up();
    int chg_cyc[3];
    int chg_val[3];
    int nchg, ndone, done_cyc, bad, bad_cyc;
    logic [7:0] prev;
    chg_cyc = '{-1, -1, -1}; chg_val = '{-1, -1, -1};
    nchg = 0; ndone = 0; done_cyc = -1; bad = 0; bad_cyc = -1; prev = 8'd0;
    reset_a();
    tgt_duty_a = 8'd3; tgt_valid_a = 1'b1;
    n_checks++; if (tgt_ready_a !== 1'b1) $display("FAIL ramp_ready_idle: got %b expected 1", tgt_ready_a); else n_pass++;
    tick();
    tgt_valid_a = 1'b0;
    for (int k = 1; k <= 3200; k++) begin
      if (duty_a !== prev) begin
        if (nchg < 3) begin chg_cyc[nchg] = k; chg_val[nchg] = int'(duty_a); end
        nchg++;
        if (ps_a !== 1'b1) begin bad++; bad_cyc = k; end
        prev = duty_a;
      end
      if (done_a === 1'b1) begin ndone++; done_cyc = k; end
      if (busy_a !== (k < 3072)) begin bad++; bad_cyc = k; end
      if (tgt_ready_a !== ((k < 3072) ? RT : 1'b1)) begin bad++; bad_cyc = k; end
      tick();
    end
    n_checks++; if (chg_cyc[0] != 1024 || chg_val[0] != 1) $display("FAIL ramp_step1: got cycle %0d value %0d expected 1024 1", chg_cyc[0], chg_val[0]); else n_pass++;
    n_checks++; if (chg_cyc[1] != 2048 || chg_val[1] != 2) $display("FAIL ramp_step2: got cycle %0d value %0d expected 2048 2", chg_cyc[1], chg_val[1]); else n_pass++;
    n_checks++; if (chg_cyc[2] != 3072 || chg_val[2] != 3) $display("FAIL ramp_step3: got cycle %0d value %0d expected 3072 3", chg_cyc[2], chg_val[2]); else n_pass++;
    n_checks++; if (nchg != 3) $display("FAIL ramp_nsteps: got %0d expected 3", nchg); else n_pass++;
    n_checks++; if (ndone != 1 || done_cyc != 3072) $display("FAIL ramp_done: got %0d pulses last at %0d expected 1 at 3072", ndone, done_cyc); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL ramp_monitor: got %0d bad cycles (last %0d) expected 0", bad, bad_cyc); else n_pass++;
  endtask

  task automatic test_same_target();
    tgt_duty_a = 8'd3; tgt_valid_a = 1'b1;
    tick();
    tgt_valid_a = 1'b0;
    n_checks++; if (done_a !== 1'b1) $display("FAIL same_done: got %b expected 1", done_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || duty_a !== 8'd3) $display("FAIL same_state: got busy %b duty %0d expected 0 3", busy_a, duty_a); else n_pass++;
    tick();
    n_checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL same_after: got done %b busy %b expected 0 0", done_a, busy_a); else n_pass++;
  endtask

  task automatic test_hold();
    int chg_cyc[4];
    int chg_val[4];
    int nchg, ndone, done_cyc, bad;
    logic [7:0] prev;
    chg_cyc = '{-1, -1, -1, -1}; chg_val = '{-1, -1, -1, -1};
    nchg = 0; ndone = 0; done_cyc = -1; bad = 0;
    ramp_a_to(8'd10);
    n_checks++; if (done_a !== 1'b1 || duty_a !== 8'd10) $display("FAIL hold_setup: got done %b duty %0d expected 1 10", done_a, duty_a); else n_pass++;
    tgt_duty_a = 8'd5; tgt_valid_a = 1'b1;
    tick();
    tgt_valid_a = 1'b0;
    for (int k = 1; k < 1023; k++) tick();
    hold_a = 1'b1;
    tick();
    n_checks++; if (duty_a !== 8'd9 || busy_a !== 1'b1) $display("FAIL hold_step_edge: got duty %0d busy %b expected 9 1", duty_a, busy_a); else n_pass++;
    for (int k = 1024; k < 1624; k++) begin
      if (duty_a !== 8'd9 || busy_a !== 1'b1 || done_a !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) $display("FAIL hold_frozen: got %0d bad cycles expected 0", bad); else n_pass++;
    hold_a = 1'b0;
    bad = 0; prev = 8'd9;
    for (int k = 1624; k <= 5700; k++) begin
      if (duty_a !== prev) begin
        if (nchg < 4) begin chg_cyc[nchg] = k; chg_val[nchg] = int'(duty_a); end
        nchg++;
        if (ps_a !== 1'b1 || int'(duty_a) != int'(prev) - 1) bad++;
        prev = duty_a;
      end
      if (done_a === 1'b1) begin ndone++; done_cyc = k; end
      tick();
    end
    n_checks++; if (chg_cyc[0] != 2560 || chg_val[0] != 8) $display("FAIL hold_resume: got cycle %0d value %0d expected 2560 8", chg_cyc[0], chg_val[0]); else n_pass++;
    n_checks++; if (chg_cyc[3] != 5632 || chg_val[3] != 5) $display("FAIL hold_final: got cycle %0d value %0d expected 5632 5", chg_cyc[3], chg_val[3]); else n_pass++;
    n_checks++; if (nchg != 4 || bad != 0) $display("FAIL hold_steps: got %0d later steps %0d bad expected 4 0", nchg, bad); else n_pass++;
    n_checks++; if (ndone != 1 || done_cyc != 5632) $display("FAIL hold_done: got %0d pulses last at %0d expected 1 at 5632", ndone, done_cyc); else n_pass++;
    bad = 0;
    hold_a = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (busy_a !== 1'b0 || duty_a !== 8'd5) bad++;
      tick();
    end
    hold_a = 1'b0;
    n_checks++; if (bad != 0) $display("FAIL hold_idle: got %0d bad cycles expected 0", bad); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    ramp_a_to(8'd7);
    n_checks++; if (done_a !== 1'b1 || duty_a !== 8'd7) $display("FAIL rmid_setup: got done %b duty %0d expected 1 7", done_a, duty_a); else n_pass++;
    tgt_duty_a = 8'd20; tgt_valid_a = 1'b1;
    tick();
    tgt_valid_a = 1'b0;
    for (int k = 0; k < 300; k++) tick();
    n_checks++; if (busy_a !== 1'b1 || duty_a !== 8'd7) $display("FAIL rmid_ramping: got busy %b duty %0d expected 1 7", busy_a, duty_a); else n_pass++;
    rst_n_a = 1'b0;
    tick();
    rst_n_a = 1'b1;
    n_checks++; if (duty_a !== 8'd0 || busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL rmid_reset: got duty %0d busy %b done %b expected 0 0 0", duty_a, busy_a, done_a); else n_pass++;
    n_checks++; if (ps_a !== 1'b1) $display("FAIL rmid_period_start: got %b expected 1", ps_a); else n_pass++;
    for (int k = 0; k < 1500; k++) begin
      if (done_a !== 1'b0 || duty_a !== 8'd0 || busy_a !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) $display("FAIL rmid_abandon: got %0d bad cycles expected 0", bad); else n_pass++;
  endtask

  task automatic test_range_b();
    int nchg, ndone, done_cyc, bad, first_cyc;
    logic [7:0] prev;
    nchg = 0; ndone = 0; done_cyc = -1; bad = 0; first_cyc = -1; prev = 8'd0;
    reset_b();
    tgt_duty_b = 8'd24; tgt_valid_b = 1'b1;
    tick();
    tgt_valid_b = 1'b0;
    for (int k = 1; k <= 6400; k++) begin
      if (duty_b !== prev) begin
        if (nchg == 0) first_cyc = k;
        nchg++;
        if (ps_b !== 1'b1 || int'(duty_b) != int'(prev) + 1 || duty_b > 8'd24) bad++;
        prev = duty_b;
      end
      if (done_b === 1'b1) begin ndone++; done_cyc = k; end
      tick();
    end
    n_checks++; if (first_cyc != 256) $display("FAIL up_first: got cycle %0d expected 256", first_cyc); else n_pass++;
    n_checks++; if (nchg != 24 || duty_b !== 8'd24 || bad != 0) $display("FAIL up_ramp: got %0d steps duty %0d bad %0d expected 24 24 0", nchg, duty_b, bad); else n_pass++;
    n_checks++; if (ndone != 1 || done_cyc != 6144) $display("FAIL up_done: got %0d pulses last at %0d expected 1 at 6144", ndone, done_cyc); else n_pass++;
    nchg = 0; ndone = 0; bad = 0;
    tgt_duty_b = 8'd0; tgt_valid_b = 1'b1;
    tick();
    tgt_valid_b = 1'b0;
    for (int k = 0; k < 6700; k++) begin
      if (duty_b !== prev) begin
        nchg++;
        if (ps_b !== 1'b1 || int'(duty_b) != int'(prev) - 1) bad++;
        prev = duty_b;
      end
      if (done_b === 1'b1) ndone++;
      tick();
    end
    n_checks++; if (nchg != 24 || duty_b !== 8'd0 || bad != 0) $display("FAIL down_ramp: got %0d steps duty %0d bad %0d expected 24 0 0", nchg, duty_b, bad); else n_pass++;
    n_checks++; if (ndone != 1 || busy_b !== 1'b0) $display("FAIL down_done: got %0d pulses busy %b expected 1 0", ndone, busy_b); else n_pass++;
  endtask

  task automatic test_retarget_b();
    int bad;
    bad = 0;
    reset_b();
    tgt_duty_b = 8'd200; tgt_valid_b = 1'b1;
    tick();
    tgt_valid_b = 1'b0;
`ifdef PWM_RAMP_RETARGET_EN
    begin
      int nchg, ndone, first_cyc;
      logic [7:0] prev;
      nchg = 0; ndone = 0; first_cyc = -1; prev = 8'd5;
      for (int k = 1; k < 2000 && duty_b !== 8'd5; k++) tick();
      n_checks++; if (duty_b !== 8'd5 || ps_b !== 1'b1) $display("FAIL rt_reach5: got duty %0d ps %b expected 5 1", duty_b, ps_b); else n_pass++;
      n_checks++; if (tgt_ready_b !== 1'b1) $display("FAIL rt_ready: got %b expected 1", tgt_ready_b); else n_pass++;
      tgt_duty_b = 8'd2; tgt_valid_b = 1'b1;
      tick();
      tgt_valid_b = 1'b0;
      for (int k = 1; k <= 1200; k++) begin
        if (duty_b !== prev) begin
          if (nchg == 0) first_cyc = k;
          nchg++;
          if (ps_b !== 1'b1 || int'(duty_b) != int'(prev) - 1 || duty_b < 8'd2) bad++;
          prev = duty_b;
        end
        if (done_b === 1'b1) ndone++;
        tick();
      end
      n_checks++; if (first_cyc != 256) $display("FAIL rt_first: got cycle %0d expected 256", first_cyc); else n_pass++;
      n_checks++; if (nchg != 3 || duty_b !== 8'd2 || bad != 0) $display("FAIL rt_descend: got %0d steps duty %0d bad %0d expected 3 2 0", nchg, duty_b, bad); else n_pass++;
      n_checks++; if (ndone != 1 || busy_b !== 1'b0) $display("FAIL rt_done: got %0d pulses busy %b expected 1 0", ndone, busy_b); else n_pass++;
    end
`else
    for (int k = 1; k <= 1600; k++) begin
      if (busy_b !== 1'b1 || tgt_ready_b !== 1'b0) bad++;
      if (k == 1280) begin
        n_checks++; if (duty_b !== 8'd5) $display("FAIL nort_at5: got duty %0d expected 5", duty_b); else n_pass++;
        tgt_duty_b = 8'd2; tgt_valid_b = 1'b1;
      end
      if (k == 1290) tgt_valid_b = 1'b0;
      tick();
    end
    n_checks++; if (bad != 0) $display("FAIL nort_ready: got %0d bad cycles expected 0", bad); else n_pass++;
    n_checks++; if (duty_b !== 8'd6) $display("FAIL nort_ignored: got duty %0d expected 6", duty_b); else n_pass++;
`endif
  endtask

  initial begin
    rst_n_a = 1'b0; tgt_valid_a = 1'b0; hold_a = 1'b0; tgt_duty_a = 8'd0;
    rst_n_b = 1'b0; tgt_valid_b = 1'b0; hold_b = 1'b0; tgt_duty_b = 8'd0;
    test_reset();
    test_ramp_up();
    test_same_target();
    test_hold();
    test_reset_mid();
    test_range_b();
    test_retarget_b();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
